// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Command buffer and result-capture stage around an external combinational
// N-bit ALU. Commands {a, b, sel} are queued in a DEPTH-entry FIFO; the FIFO
// head drives the ALU, and the ALU's sum/carry are captured into a result
// register that is offered downstream.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready. The producer holds valid and its payload stable until that
// edge; ready never depends combinationally on the same side's valid.
//
// Optional feature: define ALU_CMD_SEQ_FLAGS_EN to build the registered
// out_zero / out_dz flags. When it is undefined both flags are tied to 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      command handshake
//   in_a, in_b, in_sel     command payload (operands, opcode)
//   alu_a, alu_b, alu_sel  FIFO head to the ALU (zero when FIFO empty)
//   alu_sum, alu_cout      ALU results
//   out_valid/out_ready    result handshake
//   out_result, out_carry  registered ALU sum / carry-out
//   out_zero, out_dz       registered flags (flags build only)
//   count                  FIFO occupancy
module alu_cmd_sequencer #(
   parameter int N     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_a,
   input  logic [N-1:0]             in_b,
   input  logic [3:0]               in_sel,
   output logic [N-1:0]             alu_a,
   output logic [N-1:0]             alu_b,
   output logic [3:0]               alu_sel,
   input  logic [N-1:0]             alu_sum,
   input  logic                     alu_cout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_result,
   output logic                     out_carry,
   output logic                     out_zero,
   output logic                     out_dz,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [N-1:0] mem_a   [DEPTH];
   logic [N-1:0] mem_b   [DEPTH];
   logic [3:0]   mem_sel [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          not_empty;
   logic          push;
   logic          load;

   assign not_empty = (count != '0);

   // Full is judged on the registered count only, so a pop in the same
   // cycle never frees a slot early and out_ready cannot reach in_ready.
   assign in_ready  = rst_n && (count < FULL_COUNT);
   assign push      = in_valid && in_ready;
   assign load      = not_empty && (!out_valid || out_ready);

   assign alu_a   = not_empty ? mem_a[rd_ptr]   : '0;
   assign alu_b   = not_empty ? mem_b[rd_ptr]   : '0;
   assign alu_sel = not_empty ? mem_sel[rd_ptr] : '0;

   // Storage needs no reset: its contents are only visible while count > 0.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]   <= in_a;
         mem_b[wr_ptr]   <= in_b;
         mem_sel[wr_ptr] <= in_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (load) rd_ptr <= rd_ptr + PW'(1);
         case ({push, load})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_carry  <= 1'b0;
      end else if (load) begin
         out_valid  <= 1'b1;
         out_result <= alu_sum;
         out_carry  <= alu_cout;
      end else if (out_ready) begin
         // Drain: result fields keep their last value.
         out_valid  <= 1'b0;
      end
   end

`ifdef ALU_CMD_SEQ_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_zero <= 1'b0;
         out_dz   <= 1'b0;
      end else if (load) begin
         out_zero <= (alu_sum == '0);
         out_dz   <= (alu_sel == 4'b0011) && (alu_b == '0);
      end
   end
`else
   assign out_zero = 1'b0;
   assign out_dz   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer. The bench provides the combinational ALU
// (add, sub with borrow, mul low byte, div, xor, and) that the sequencer
// wraps, and checks the sequencer's queuing, latency and capture behaviour.
module tb_alu_cmd_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [3:0] in_sel;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_sum;
   logic       alu_cout;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_carry;
   logic       out_zero;
   logic       out_dz;
   logic [2:0] count;

   int tests = 0;
   int fails = 0;
   bit mon_en = 0;
   logic [8:0] exp_q[$];

   alu_cmd_sequencer #(.N(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_sum(alu_sum), .alu_cout(alu_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_carry(out_carry),
      .out_zero(out_zero), .out_dz(out_dz),
      .count(count)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ALU attached to the sequencer ----------------
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
      logic [15:0] p;
      case (sel)
         4'b0000: return {1'b0, a} + {1'b0, b};
         4'b0001: return {1'b0, a} - {1'b0, b};
         4'b0010: begin
            p = a * b;
            return {|p[15:8], p[7:0]};
         end
         4'b0011: return (b == 8'd0) ? {1'b0, 8'hFF} : {1'b0, a / b};
         4'b1010: return {1'b0, a ^ b};
         default: return {1'b0, a & b};
      endcase
   endfunction

   always_comb {alu_cout, alu_sum} = alu_f(alu_a, alu_b, alu_sel);

   function automatic logic flag_exp(input logic f);
`ifdef ALU_CMD_SEQ_FLAGS_EN
      return f;
`else
      return 1'b0;
`endif
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result monitor: compares every handed-off result with the expected queue.
   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {out_carry, out_result}, 32'hDEAD);
         end else begin
            check("stream_order", {out_carry, out_result}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks (start and end at posedge + 1) ----------------
   task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_sel   = sel;
      @(negedge clk);
      check("push_ready", in_ready, 1'b1);
      exp_q.push_back(alu_f(a, b, sel));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] sel;
      logic [7:0] res;
      logic       carry;
      logic       zero;
      logic       dz;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v);
      in_valid = 1'b1;
      in_a     = v.a;
      in_b     = v.b;
      in_sel   = v.sel;
      @(negedge clk);
      check("vec_ready", in_ready, 1'b1);
      check("vec_no_bypass", {alu_a, alu_b, alu_sel}, 20'h0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("vec_count1", count, 3'd1);
      check("vec_alu_drive", {alu_a, alu_b, alu_sel}, {v.a, v.b, v.sel});
      check("vec_early_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("vec_valid", out_valid, 1'b1);
      check("vec_result", {out_carry, out_result}, {v.carry, v.res});
      check("vec_flags", {out_zero, out_dz}, {flag_exp(v.zero), flag_exp(v.dz)});
      check("vec_count0", count, 3'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("vec_drained", out_valid, 1'b0);
      check("vec_hold", out_result, v.res);
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vecs[0] = '{8'd200, 8'd100, 4'b0000, 8'd44,  1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'd5,   8'd7,   4'b0001, 8'hFE,  1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'd9,   8'd0,   4'b0011, 8'hFF,  1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'd3,   8'd3,   4'b1010, 8'h00,  1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'd255, 8'd1,   4'b0000, 8'h00,  1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'd16,  8'd16,  4'b0010, 8'h00,  1'b1, 1'b1, 1'b0};
      vecs[6] = '{8'd100, 8'd7,   4'b0011, 8'd14,  1'b0, 1'b0, 1'b0};
      vecs[7] = '{8'd7,   8'd5,   4'b0001, 8'd2,   1'b0, 1'b0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sel    = '0;
      out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_outputs", {out_valid, out_carry, out_zero, out_dz, out_result}, 12'h0);
      check("rst_count", count, 3'd0);
      check("rst_alu", {alu_a, alu_b, alu_sel}, 20'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Single-command vectors, one at a time
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Fill and backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'(i * 20 + 1), 8'(i + 2), 4'b0000);
      @(negedge clk);
      check("fill_count", count, 3'd4);
      check("fill_in_ready", in_ready, 1'b0);
      check("fill_held_valid", out_valid, 1'b1);
      check("fill_held_result", {out_carry, out_result}, exp_q[0]);
      // Offer a sixth command while full: it must be refused.
      in_valid = 1'b1;
      in_a     = 8'hAA;
      in_b     = 8'h55;
      in_sel   = 4'b0000;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("full_refuse_count", count, 3'd4);
      check("frozen_result", {out_carry, out_result}, exp_q[0]);
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("fill_drain_valid", out_valid, 1'b1);
         check("fill_drain_order", {out_carry, out_result}, exp_q.pop_front());
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("fill_empty_valid", out_valid, 1'b0);
      check("fill_empty_count", count, 3'd0);
      @(posedge clk);
      #1;

      // Simultaneous push and pop at count = 2
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(8'(i + 50), 8'(i * 3), 4'b0001);
      mon_en    = 1'b1;
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         in_valid = 1'b1;
         in_a     = 8'(j * 25 + 3);
         in_b     = 8'(j * 11 + 200);
         in_sel   = 4'b0000;
         @(negedge clk);
         check("steady_count", count, 3'd2);
         check("steady_ready", in_ready, 1'b1);
         exp_q.push_back(alu_f(in_a, in_b, in_sel));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("steady_all_out", exp_q.size(), 0);
      check("steady_idle", {out_valid, count}, 4'h0);
      @(posedge clk);
      #1;

      // Reset mid-stream with queued commands and a pending result
      mon_en    = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(i + 10), 8'd5, 4'b0000);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", {out_valid, out_carry, out_zero, out_dz, out_result}, 12'h0);
      check("mid_rst_count", count, 3'd0);
      check("mid_rst_ready", in_ready, 1'b0);
      check("mid_rst_alu", {alu_a, alu_b, alu_sel}, 20'h0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      mon_en    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale_result", {out_valid, count}, 4'h0);
         @(posedge clk);
         #1;
      end
      push(8'd7, 8'd9, 4'b0000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("post_rst_delivered", exp_q.size(), 0);
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
